// File: rtl/morph_program_sequencer_pkg.sv
// Shared definitions for the morphologic program sequencer.
// - Sequencer state encoding (3-bit).
// - Opcode field widths and bit offsets:
//   opcode = {el[8:0], morph_op[2:0], in_select, logic_op[2:0]}.
// - The morph_op/logic_op code points that the processor decodes.
// - A helper that clamps a requested program length to the program depth.
package morph_program_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_TX_REQ  = 3'd3,
    ST_TX_WAIT = 3'd4
  } state_t;

  localparam int EL_W       = 9;
  localparam int MORPH_OP_W = 3;
  localparam int SEL_W      = 1;
  localparam int LOGIC_OP_W = 3;
  localparam int OPCODE_W   = EL_W + MORPH_OP_W + SEL_W + LOGIC_OP_W;

  localparam int LOGIC_OP_LSB = 0;
  localparam int SEL_LSB      = LOGIC_OP_LSB + LOGIC_OP_W;
  localparam int MORPH_OP_LSB = SEL_LSB + SEL_W;
  localparam int EL_LSB       = MORPH_OP_LSB + MORPH_OP_W;

  localparam logic [MORPH_OP_W-1:0] MORPH_NOP    = 3'd0;
  localparam logic [MORPH_OP_W-1:0] MORPH_ERODE  = 3'd1;
  localparam logic [MORPH_OP_W-1:0] MORPH_DILATE = 3'd2;
  localparam logic [MORPH_OP_W-1:0] MORPH_OPEN   = 3'd3;
  localparam logic [MORPH_OP_W-1:0] MORPH_CLOSE  = 3'd4;

  localparam logic [LOGIC_OP_W-1:0] LOGIC_PASS = 3'd0;
  localparam logic [LOGIC_OP_W-1:0] LOGIC_AND  = 3'd1;
  localparam logic [LOGIC_OP_W-1:0] LOGIC_OR   = 3'd2;
  localparam logic [LOGIC_OP_W-1:0] LOGIC_XOR  = 3'd3;
  localparam logic [LOGIC_OP_W-1:0] LOGIC_NOT  = 3'd4;

  // Lengths beyond the stored program would read past the register file.
  function automatic int clamp_len(input int len, input int depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/morph_program_sequencer_if.sv
// Control/data bundle between the debug/control side (master) and the
// sequencer (slave), including the processor and TX packager signals.
// - wr_en/wr_addr/wr_data : program write port
// - prog_len/start        : run request
// - opcode/proc_ce/proc_clear : processor drive
// - tx_start/tx_busy      : serial TX handshake
// - busy/done             : run status
interface morph_program_sequencer_if #(
  parameter int AddressWidth = 2,
  parameter int OpcodeWidth  = 16
) ();
  logic                    wr_en;
  logic [AddressWidth-1:0] wr_addr;
  logic [OpcodeWidth-1:0]  wr_data;
  logic [AddressWidth:0]   prog_len;
  logic                    start;
  logic [OpcodeWidth-1:0]  opcode;
  logic                    proc_ce;
  logic                    proc_clear;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    busy;
  logic                    done;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, tx_busy,
    input  opcode, proc_ce, proc_clear, tx_start, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, tx_busy,
    output opcode, proc_ce, proc_clear, tx_start, busy, done
  );
endinterface

// File: rtl/morph_program_regfile.sv
// Program store: 2**AddressWidth opcode registers.
// - clk, rst : clock, asynchronous active-high reset (clears every word)
// - we, waddr, wdata : synchronous write port
// - raddr, rdata     : combinational read port
module morph_program_regfile
  import morph_program_sequencer_pkg::*;
#(
  parameter int AddressWidth = 2,
  parameter int OpcodeWidth  = OPCODE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AddressWidth-1:0] waddr,
  input  logic [OpcodeWidth-1:0]  wdata,
  input  logic [AddressWidth-1:0] raddr,
  output logic [OpcodeWidth-1:0]  rdata
);
  localparam int Depth = 2 ** AddressWidth;

  logic [OpcodeWidth-1:0] mem [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/morph_program_sequencer.sv
// Runs a stored opcode program through the morphologic processor, then
// hands the result to the serial TX packager with a start/busy handshake.
// - clk, rst : clock, asynchronous active-high reset
// - bus      : slave side of morph_program_sequencer_if (program write,
//              start/prog_len, opcode/proc_ce/proc_clear, tx_start/tx_busy,
//              busy/done)
module morph_program_sequencer
  import morph_program_sequencer_pkg::*;
#(
  parameter int AddressWidth = 2,
  parameter int OpcodeWidth  = OPCODE_W
) (
  input logic                     clk,
  input logic                     rst,
  morph_program_sequencer_if.slave bus
);
  localparam int Depth = 2 ** AddressWidth;
  localparam int LenW  = AddressWidth + 1;

  state_t                  state, state_d;
  logic [AddressWidth-1:0] pc, pc_d;
  logic [LenW-1:0]         len_q, len_d;
  logic                    done_q, done_d;
  logic                    last_op;
  logic                    prog_we;

  // The program is only writable while idle, so a run sees a stable image.
  assign prog_we = bus.wr_en && (state == ST_IDLE);

  morph_program_regfile #(
    .AddressWidth(AddressWidth),
    .OpcodeWidth (OpcodeWidth)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (prog_we),
    .waddr(bus.wr_addr),
    .wdata(bus.wr_data),
    .raddr(pc),
    .rdata(bus.opcode)
  );

  assign last_op = ({1'b0, pc} == (len_q - LenW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.prog_len != '0) begin
            len_d   = LenW'(clamp_len(int'(bus.prog_len), Depth));
            pc_d    = '0;
            state_d = ST_CLEAR;
          end else begin
            // Empty program: report completion without touching the datapath.
            done_d = 1'b1;
          end
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (last_op) begin
          pc_d    = '0;
          state_d = ST_TX_REQ;
        end else begin
          pc_d = pc + AddressWidth'(1);
        end
      end
      ST_TX_REQ: begin
        if (bus.tx_busy) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!bus.tx_busy) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from the registered state so reset clears them immediately.
  assign bus.proc_clear = (state == ST_CLEAR);
  assign bus.proc_ce    = (state == ST_RUN);
  assign bus.tx_start   = (state == ST_TX_REQ);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_morph_program_sequencer.sv
// Self-checking bench for morph_program_sequencer with a behavioural
// program/timing model and randomized programs and handshake timing.
module tb_morph_program_sequencer;
  import morph_program_sequencer_pkg::*;

  localparam int AW    = 2;
  localparam int OW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  morph_program_sequencer_if #(.AddressWidth(AW), .OpcodeWidth(OW)) bus ();

  morph_program_sequencer #(.AddressWidth(AW), .OpcodeWidth(OW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [OW-1:0] mem_model [DEPTH];

  int            cap_clear_cnt, cap_clear_at, cap_ce_first;
  int            cap_tx_cnt, cap_tx_at, cap_tx_last;
  int            cap_done_at, cap_done_cnt, cap_other;
  logic          cap_busy_at_done;
  logic [OW-1:0] cap_ops [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [OW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    mem_model[addr] = data;
  endtask

  // Starts a run and records what the DUT does, tick by tick (tick 1 is the
  // first cycle after the start edge). tx_busy rises bdelay ticks after
  // tx_start is first seen and falls bhold ticks later.
  task automatic run_capture(input int len, input int bdelay, input int bhold,
                             input bit preset, input bit wr_in_run,
                             input bit start_in_wait, input bit same_wr,
                             input logic [AW-1:0] sw_addr, input logic [OW-1:0] sw_data);
    int post;
    int rel;
    cap_clear_cnt = 0; cap_clear_at = -1; cap_ce_first = -1;
    cap_tx_cnt = 0; cap_tx_at = -1; cap_tx_last = -1;
    cap_done_at = -1; cap_done_cnt = 0; cap_other = 0;
    cap_busy_at_done = 1'bx;
    cap_ops.delete();
    post = 0;
    bus.prog_len = len[AW:0];
    bus.start    = 1'b1;
    if (preset) bus.tx_busy = 1'b1;
    if (same_wr) begin
      bus.wr_en = 1'b1; bus.wr_addr = sw_addr; bus.wr_data = sw_data;
      mem_model[sw_addr] = sw_data;
    end
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int k = 1; k < 300 && post < 3; k++) begin
      if (bus.proc_clear) begin cap_clear_cnt++; cap_clear_at = k; end
      if (bus.proc_ce) begin
        if (cap_ce_first < 0) cap_ce_first = k;
        cap_ops.push_back(bus.opcode);
      end
      if (bus.tx_start) begin
        if (cap_tx_at < 0) cap_tx_at = k;
        cap_tx_cnt++;
        cap_tx_last = k;
      end
      if (cap_done_at >= 0 && (bus.proc_ce || bus.proc_clear || bus.tx_start)) cap_other++;
      if (bus.done) begin
        if (cap_done_at < 0) begin cap_done_at = k; cap_busy_at_done = bus.busy; end
        cap_done_cnt++;
      end
      if (cap_done_at >= 0) post++;
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      if (wr_in_run && bus.proc_ce && cap_ops.size() == 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 16'hFFFF;
      end
      if (cap_tx_at >= 0) begin
        rel = k - cap_tx_at;
        if (rel == bdelay) bus.tx_busy = 1'b1;
        if (rel == bdelay + bhold) bus.tx_busy = 1'b0;
        if (start_in_wait && rel == bdelay + 1) begin
          bus.start = 1'b1; bus.prog_len = 3'd2;
        end
      end
      tick();
    end
    bus.tx_busy = 1'b0;
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    n_tests++;
    if (cap_done_at < 0) begin
      n_fail++;
      $display("FAIL run_timeout: no done pulse within cycle budget (len=%0d)", len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.prog_len = '0;
    bus.start = 0; bus.tx_busy = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    tick(); tick();
    n_tests++;
    if ({bus.proc_ce, bus.proc_clear, bus.tx_start, bus.busy, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.proc_ce, bus.proc_clear, bus.tx_start, bus.busy, bus.done});
    end
    n_tests++;
    if (bus.opcode !== 16'h0) begin
      n_fail++; $display("FAIL reset_opcode: got %h want 0000", bus.opcode);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    write_word(2'd0, 16'h5D11);
    write_word(2'd1, 16'h4B9B);
    run_capture(2, 1, 2, 0, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_clear_cnt !== 1 || cap_clear_at !== 1) begin
      n_fail++; $display("FAIL basic_clear: got cnt=%0d at=%0d want cnt=1 at=1", cap_clear_cnt, cap_clear_at);
    end
    n_tests++;
    if (cap_ops.size() !== 2 || cap_ce_first !== 2) begin
      n_fail++; $display("FAIL basic_ce: got n=%0d first=%0d want n=2 first=2", cap_ops.size(), cap_ce_first);
    end else begin
      n_tests++;
      if (cap_ops[0] !== 16'h5D11 || cap_ops[1] !== 16'h4B9B) begin
        n_fail++; $display("FAIL basic_opcodes: got %h %h want 5d11 4b9b", cap_ops[0], cap_ops[1]);
      end
    end
    n_tests++;
    if (cap_tx_at !== 4) begin
      n_fail++; $display("FAIL basic_tx_rise: got tick %0d want 4", cap_tx_at);
    end
  endtask

  task automatic test_tx_handshake();
    run_capture(2, 5, 10, 0, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_tx_cnt !== 6 || (cap_tx_last - cap_tx_at + 1) !== 6) begin
      n_fail++; $display("FAIL tx_hold: got cnt=%0d span=%0d want 6", cap_tx_cnt, cap_tx_last - cap_tx_at + 1);
    end
    n_tests++;
    if (cap_done_at !== 20 || cap_done_cnt !== 1) begin
      n_fail++; $display("FAIL tx_done: got at=%0d cnt=%0d want at=20 cnt=1", cap_done_at, cap_done_cnt);
    end
    n_tests++;
    if (cap_busy_at_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL tx_idle: got busy=%b/%b want 0/0", cap_busy_at_done, bus.busy);
    end
  endtask

  task automatic test_zero_len();
    run_capture(0, 0, 1, 0, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_done_at !== 1 || cap_done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_done: got at=%0d cnt=%0d want at=1 cnt=1", cap_done_at, cap_done_cnt);
    end
    n_tests++;
    if (cap_clear_cnt !== 0 || cap_ops.size() !== 0 || cap_tx_cnt !== 0 || cap_busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL zero_activity: got clear=%0d ce=%0d tx=%0d busy=%b want 0 0 0 0",
                         cap_clear_cnt, cap_ops.size(), cap_tx_cnt, cap_busy_at_done);
    end
  endtask

  task automatic test_clamp();
    write_word(2'd0, 16'h1111);
    write_word(2'd1, 16'h2222);
    write_word(2'd2, 16'h3333);
    write_word(2'd3, 16'h4444);
    run_capture(7, 0, 1, 0, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_ops.size() !== DEPTH) begin
      n_fail++; $display("FAIL clamp_count: got %0d want %0d", cap_ops.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_tests++;
        if (cap_ops[i] !== mem_model[i]) begin
          n_fail++; $display("FAIL clamp_op%0d: got %h want %h", i, cap_ops[i], mem_model[i]);
        end
      end
    end
    n_tests++;
    if (cap_tx_at !== 2 + DEPTH) begin
      n_fail++; $display("FAIL clamp_tx_rise: got %0d want %0d", cap_tx_at, 2 + DEPTH);
    end
  endtask

  task automatic test_locked();
    run_capture(4, 0, 3, 0, 1, 1, 0, '0, '0);
    n_tests++;
    if (cap_done_cnt !== 1 || cap_other !== 0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL locked_start_ignored: got done=%0d extra=%0d busy=%b want 1 0 0",
                         cap_done_cnt, cap_other, bus.busy);
    end
    run_capture(1, 0, 1, 0, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_ops.size() !== 1 || cap_ops[0] !== mem_model[0]) begin
      n_fail++; $display("FAIL locked_write_ignored: got %h want %h",
                         (cap_ops.size() > 0) ? cap_ops[0] : 16'hxxxx, mem_model[0]);
    end
  endtask

  task automatic test_preset_busy();
    run_capture(1, 0, 3, 1, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_tx_cnt !== 1 || cap_done_at !== 7) begin
      n_fail++; $display("FAIL preset_busy: got tx=%0d done_at=%0d want tx=1 done_at=7", cap_tx_cnt, cap_done_at);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    int len, bd, bh, exp_len;
    bit pre, sw;
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < 2; w++) begin
        r = $urandom();
        write_word(r[17:16], r[15:0]);
      end
      len = $urandom_range(0, 7);
      bd  = $urandom_range(0, 3);
      bh  = $urandom_range(1, 4);
      pre = (bd == 0) && ($urandom_range(0, 1) == 1);
      sw  = ($urandom_range(0, 1) == 1);
      r   = $urandom();
      run_capture(len, bd, bh, pre, 0, 0, sw, r[17:16], r[15:0]);
      exp_len = (len > DEPTH) ? DEPTH : len;
      n_tests++;
      if (cap_ops.size() !== exp_len) begin
        n_fail++; $display("FAIL rand%0d_ce_count: got %0d want %0d", it, cap_ops.size(), exp_len);
      end else begin
        for (int i = 0; i < exp_len; i++) begin
          n_tests++;
          if (cap_ops[i] !== mem_model[i]) begin
            n_fail++; $display("FAIL rand%0d_op%0d: got %h want %h", it, i, cap_ops[i], mem_model[i]);
          end
        end
      end
      n_tests++;
      if (exp_len == 0) begin
        if (cap_done_at !== 1 || cap_clear_cnt !== 0 || cap_tx_cnt !== 0) begin
          n_fail++; $display("FAIL rand%0d_zero: got done_at=%0d clear=%0d tx=%0d want 1 0 0",
                             it, cap_done_at, cap_clear_cnt, cap_tx_cnt);
        end
      end else if (cap_clear_at !== 1 || cap_clear_cnt !== 1 || cap_tx_at !== 2 + exp_len ||
                   cap_tx_cnt !== bd + 1 || cap_done_at !== 3 + exp_len + bd + bh) begin
        n_fail++; $display("FAIL rand%0d_timing: got clear=%0d/%0d tx=%0d/%0d done=%0d want 1/1 %0d/%0d %0d",
                           it, cap_clear_at, cap_clear_cnt, cap_tx_at, cap_tx_cnt, cap_done_at,
                           2 + exp_len, bd + 1, 3 + exp_len + bd + bh);
      end
      n_tests++;
      if (cap_done_cnt !== 1 || cap_other !== 0 || cap_busy_at_done !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_done: got cnt=%0d extra=%0d busy=%b want 1 0 0",
                           it, cap_done_cnt, cap_other, cap_busy_at_done);
      end
    end
  endtask

  task automatic test_reset_midrun();
    write_word(2'd0, 16'hA001);
    write_word(2'd1, 16'hB002);
    bus.prog_len = 3'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.proc_ce !== 1'b1 || bus.opcode !== 16'hB002) begin
      n_fail++; $display("FAIL midrun_pc1: got ce=%b op=%h want ce=1 op=b002", bus.proc_ce, bus.opcode);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.proc_ce, bus.proc_clear, bus.tx_start, bus.busy, bus.done} !== 5'b0 || bus.opcode !== 16'h0) begin
      n_fail++; $display("FAIL midrun_async_reset: got %b op=%h want 00000 op=0000",
                         {bus.proc_ce, bus.proc_clear, bus.tx_start, bus.busy, bus.done}, bus.opcode);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    tick();
    n_tests++;
    if (bus.opcode !== 16'h0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_after_release: got op=%h busy=%b want 0000 0", bus.opcode, bus.busy);
    end
    write_word(2'd2, 16'h1234);
    run_capture(3, 0, 1, 0, 0, 0, 0, '0, '0);
    n_tests++;
    if (cap_ops.size() !== 3 || cap_ops[0] !== 16'h0 || cap_ops[1] !== 16'h0 || cap_ops[2] !== 16'h1234) begin
      n_fail++; $display("FAIL midrun_rerun: got n=%0d want 3 ops 0000 0000 1234", cap_ops.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx_handshake();
    test_zero_len();
    test_clamp();
    test_locked();
    test_preset_busy();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
